config_frame_sender: RTL and testbench

- Transmit end of the instrumentation reconfiguration bus that the per-block firmware receivers listen to (`tracing` low, `configId`/`configData` byte stream).
- Accepts one frame command from the host controller: a target config ID plus a byte count.
- Buffers the full payload, then drives it onto the bus as one gap-free burst.
- Gap-free bursts are required because receivers advance their byte counter on every cycle their ID is present, and reset it on any other ID.

---
 rtl/config_frame_sender.sv | 154 +++++++++++++++
 tb/tb_config_frame_sender.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_sender.sv
// Transmit end of the reconfiguration bus: buffers one frame, then sends it as a gap-free burst.
module config_frame_sender #(
  parameter int unsigned MAX_FRAME_BYTES = 32,
  parameter logic [7:0]  IDLE_CONFIG_ID  = 8'hFF,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trace_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_length,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [7:0] data_byte,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       frame_done,
  output logic       cmd_error
);

  localparam int unsigned CW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int unsigned AW = (MAX_FRAME_BYTES > 1) ? $clog2(MAX_FRAME_BYTES) : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_e;

  state_e          state_q, state_d;
  logic            tracing_q, tracing_d;
  logic [7:0]      config_id_q, config_id_d;
  logic [7:0]      config_data_q, config_data_d;
  logic            frame_done_q, frame_done_d;
  logic            cmd_error_q, cmd_error_d;
  logic [7:0]      target_q, target_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            buf_we_c;
  logic [7:0]      buf_mem_q [MAX_FRAME_BYTES];

  assign cmd_ready  = (state_q == ST_IDLE);
  assign data_ready = (state_q == ST_LOAD);
  assign tracing    = tracing_q;
  assign configId   = config_id_q;
  assign configData = config_data_q;
  assign frame_done = frame_done_q;
  assign cmd_error  = cmd_error_q;

  // State, bus outputs and counters; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tracing_q     <= 1'b0;
      config_id_q   <= IDLE_CONFIG_ID;
      config_data_q <= 8'h00;
      frame_done_q  <= 1'b0;
      cmd_error_q   <= 1'b0;
      target_q      <= 8'h00;
      len_q         <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      tracing_q     <= tracing_d;
      config_id_q   <= config_id_d;
      config_data_q <= config_data_d;
      frame_done_q  <= frame_done_d;
      cmd_error_q   <= cmd_error_d;
      target_q      <= target_d;
      len_q         <= len_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  // Payload buffer; contents are only meaningful below the current write count.
  always_ff @(posedge clk) begin
    if (buf_we_c) begin
      buf_mem_q[AW'(wr_cnt_q)] <= data_byte;
    end
  end

  // Next-state and registered bus values; the bus idles at IDLE_CONFIG_ID outside a burst.
  always_comb begin
    state_d       = state_q;
    tracing_d     = 1'b0;
    config_id_d   = IDLE_CONFIG_ID;
    config_data_d = 8'h00;
    frame_done_d  = 1'b0;
    cmd_error_d   = 1'b0;
    target_d      = target_q;
    len_d         = len_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    buf_we_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tracing_d = trace_en;
        wr_cnt_d  = '0;
        rd_cnt_d  = '0;
        if (cmd_valid) begin
          if ((cmd_length == 8'd0) || (cmd_length > 8'(MAX_FRAME_BYTES)) ||
              (cmd_target == IDLE_CONFIG_ID)) begin
            cmd_error_d = 1'b1;
          end else begin
            target_d  = cmd_target;
            len_d     = CW'(cmd_length);
            tracing_d = 1'b0;
            state_d   = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (data_valid) begin
          buf_we_c = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q == len_q - CW'(1)) begin
            // Byte 0 goes out the very next cycle; a 1-byte frame bypasses the buffer.
            state_d       = ST_SEND;
            config_id_d   = target_q;
            config_data_d = (len_q == CW'(1)) ? data_byte : buf_mem_q[0];
            rd_cnt_d      = CW'(1);
          end
        end
      end
      ST_SEND: begin
        if (rd_cnt_q == len_q) begin
          state_d   = ST_GAP;
          gap_cnt_d = GW'(1);
        end else begin
          config_id_d   = target_q;
          config_data_d = buf_mem_q[AW'(rd_cnt_q)];
          rd_cnt_d      = rd_cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES)) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_config_frame_sender.sv
// Scoreboard bench for config_frame_sender: expected bus beats queued at command time, checked as they appear.
module tb_config_frame_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trace_en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_target = 8'h00;
  logic [7:0] cmd_length = 8'h00;
  logic       data_valid = 1'b0;
  logic [7:0] data_byte = 8'h00;
  logic       cmd_ready, data_ready, tracing, frame_done, cmd_error;
  logic [7:0] configId, configData;

  always #5 clk = ~clk;

  config_frame_sender #(
    .MAX_FRAME_BYTES(32),
    .IDLE_CONFIG_ID (8'hFF),
    .GAP_CYCLES     (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trace_en  (trace_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_length(cmd_length),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_byte (data_byte),
    .tracing   (tracing),
    .configId  (configId),
    .configData(configData),
    .frame_done(frame_done),
    .cmd_error (cmd_error)
  );

  typedef struct {
    logic [7:0] id;
    logic [7:0] data;
    bit         first;
    bit         last;
  } beat_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         done_cnt = 0;
  int         exp_done = 0;
  bit         loading = 1'b0;
  logic [7:0] pl [64];
  beat_t      exp_q [$];
  logic [7:0] prev_id = 8'hFF;
  bit         prev_last = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: pops one expected beat per non-idle ID cycle.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_id   = 8'hFF;
      prev_last = 1'b0;
    end else begin
      if (frame_done) begin
        done_cnt++;
        check_val("done_trc", 32'(tracing), 32'd0);
      end
      if (configId != 8'hFF) begin
        if (loading) check_val("early", 32'(configId), 32'hFF);
        if (exp_q.size() == 0) begin
          check_val("unexp_id", 32'(configId), 32'hFF);
          prev_last = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check_val("id", 32'(configId), 32'(e.id));
          check_val("data", 32'(configData), 32'(e.data));
          check_val("send_trc", 32'(tracing), 32'd0);
          if (e.first) begin
            check_val("latency", 32'(cyc), 32'(first_cyc));
            check_val("gap_id", 32'(prev_id), 32'hFF);
          end else begin
            check_val("contig", 32'(prev_id), 32'(e.id));
          end
          prev_last = e.last;
        end
      end else begin
        if (prev_last) check_val("gap_data", 32'(configData), 32'd0);
        prev_last = 1'b0;
      end
      prev_id = configId;
    end
  end

  task automatic do_cmd(input logic [7:0] t, input logic [7:0] l, output bit ok);
    int n;
    n = 0;
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_length = l;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (!ok) check_val("cmd_timeout", 32'd0, 32'd1);
    else @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame(input logic [7:0] t, input int l, input int stall_at, input int stall_n);
    bit ok;
    int n;
    do_cmd(t, 8'(l), ok);
    if (!ok) return;
    check_val("acc_err", 32'(cmd_error), 32'd0);
    check_val("trc_fall", 32'(tracing), 32'd0);
    loading = 1'b1;
    for (int k = 0; k < l; k++) exp_q.push_back(beat_t'{t, pl[k], k == 0, k == l - 1});
    for (int k = 0; k < l; k++) begin
      n = 0;
      if (k == stall_at) begin
        repeat (stall_n) @(posedge clk);
        #1;
      end
      data_valid = 1'b1;
      data_byte  = pl[k];
      while (!data_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!data_ready) begin
        check_val("data_timeout", 32'd0, 32'd1);
        data_valid = 1'b0;
        loading    = 1'b0;
        return;
      end
      @(posedge clk);
      #1 data_valid = 1'b0;
    end
    first_cyc = cyc;
    loading   = 1'b0;
  endtask

  task automatic reject(input logic [7:0] t, input logic [7:0] l);
    bit   ok;
    logic tr0;
    tr0 = tracing;
    do_cmd(t, l, ok);
    if (ok) begin
      check_val("rej_err", 32'(cmd_error), 32'd1);
      check_val("rej_ready", 32'(cmd_ready), 32'd1);
      check_val("rej_id", 32'(configId), 32'hFF);
      check_val("rej_trc", 32'(tracing), 32'(tr0));
      @(posedge clk);
      #1 check_val("rej_pulse", 32'(cmd_error), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit ok;
    trace_en = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_id", 32'(configId), 32'hFF);
    check_val("rst_trc", 32'(tracing), 32'd0);
    check_val("rst_data", 32'(configData), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_err", 32'(cmd_error), 32'd0);
    check_val("rst_cmd_rdy", 32'(cmd_ready), 32'd1);
    check_val("rst_dat_rdy", 32'(data_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_val("trc_on", 32'(tracing), 32'd1);

    // Basic 4-byte frame
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    frame(8'h03, 4, -1, 0);
    exp_done++;
    wait_done(ok);
    @(negedge clk);
    check_val("trc_resume", 32'(tracing), 32'd1);

    // Same frame with a 3-cycle payload stall
    frame(8'h03, 4, 2, 3);
    exp_done++;
    wait_done(ok);

    // Illegal commands
    @(posedge clk);
    #1;
    reject(8'h03, 8'd0);
    reject(8'h03, 8'd33);
    reject(8'hFF, 8'd4);

    // Max-length frame followed by a command in the frame_done cycle
    for (int k = 0; k < 32; k++) pl[k] = 8'(k * 7 + 1);
    frame(8'h01, 32, -1, 0);
    exp_done++;
    wait_done(ok);
    check_val("b2b_ready", 32'(cmd_ready), 32'd1);
    pl[0] = 8'h5A; pl[1] = 8'hA5;
    frame(8'h02, 2, -1, 0);
    exp_done++;
    wait_done(ok);

    // Reset during the second burst byte
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD;
    frame(8'h05, 4, -1, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_id", 32'(configId), 32'hFF);
    check_val("mid_trc", 32'(tracing), 32'd0);
    check_val("mid_data", 32'(configData), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("post_cmd_rdy", 32'(cmd_ready), 32'd1);
    check_val("post_dat_rdy", 32'(data_ready), 32'd0);
    check_val("post_id", 32'(configId), 32'hFF);

    // 12-byte firmware load to a receiver ID
    for (int k = 0; k < 12; k++) pl[k] = 8'(8'h80 + k);
    frame(8'h2A, 12, -1, 0);
    exp_done++;
    wait_done(ok);
    @(negedge clk);
    check_val("fw_trc", 32'(tracing), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check_val("done_cnt", 32'(done_cnt), 32'(exp_done));
    check_val("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
